reg_file_mp: RTL and testbench

Parametrised multi-port register file for the pipelined datapath. It replaces the single-write, negedge-read register file. It has two registered read ports, two write ports with defined collision priority, write-through bypass, an optional hardwired-zero register, and a sequenced clear engine that zeroes the array after reset or on request. It sits between decode (reads) and write-back (writes).

---
 rtl/reg_file_mp.sv | 128 ++++++++++++
 tb/tb_reg_file_mp.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file: two registered read ports with write-through bypass,
// two write ports (port 1 wins on collision), optional hardwired zero, clear engine.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    output logic              ready_o,
    input  logic [ADDR_W-1:0] RSaddr_i,
    input  logic [ADDR_W-1:0] RTaddr_i,
    output logic [DATA_W-1:0] RSdata_o,
    output logic [DATA_W-1:0] RTdata_o,
    input  logic              WE0_i,
    input  logic [ADDR_W-1:0] WA0_i,
    input  logic [DATA_W-1:0] WD0_i,
    input  logic              WE1_i,
    input  logic [ADDR_W-1:0] WA1_i,
    input  logic [DATA_W-1:0] WD1_i
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   clr_cnt_reg;
    logic                ready_reg;
    logic [DATA_W-1:0]   rs_data_reg;
    logic [DATA_W-1:0]   rt_data_reg;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                run_op;
    logic                we0_ok;
    logic                we1_ok;
    logic [DATA_W-1:0]   rs_data_next;
    logic [DATA_W-1:0]   rt_data_next;

    // Priority: hardwired zero, then port 1 bypass, then port 0 bypass, then array.
    function automatic logic [DATA_W-1:0] read_sel(
        input logic [ADDR_W-1:0] addr,
        input logic              we0,
        input logic [ADDR_W-1:0] wa0,
        input logic [DATA_W-1:0] wd0,
        input logic              we1,
        input logic [ADDR_W-1:0] wa1,
        input logic [DATA_W-1:0] wd1,
        input logic [DATA_W-1:0] stored
    );
        if (ZERO_REG != 0 && addr == '0)
            return '0;
        else if (we1 && wa1 == addr)
            return wd1;
        else if (we0 && wa0 == addr)
            return wd0;
        else
            return stored;
    endfunction

    assign run_op = (state_reg == ST_RUN) && !clear_i;
    assign we0_ok = run_op && WE0_i && !(ZERO_REG != 0 && WA0_i == '0);
    assign we1_ok = run_op && WE1_i && !(ZERO_REG != 0 && WA1_i == '0);

    assign rs_data_next = read_sel(RSaddr_i, WE0_i, WA0_i, WD0_i,
                                   WE1_i, WA1_i, WD1_i, mem[RSaddr_i]);
    assign rt_data_next = read_sel(RTaddr_i, WE0_i, WA0_i, WD0_i,
                                   WE1_i, WA1_i, WD1_i, mem[RTaddr_i]);

    // Array has no reset; the clear engine owns it while in CLEAR.
    // Port 1 is written last so it wins an address collision.
    always_ff @(posedge clk_i) begin
        if (state_reg == ST_CLEAR) begin
            mem[clr_cnt_reg] <= '0;
        end else begin
            if (we0_ok)
                mem[WA0_i] <= WD0_i;
            if (we1_ok)
                mem[WA1_i] <= WD1_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= ST_CLEAR;
            clr_cnt_reg <= '0;
            ready_reg   <= 1'b0;
            rs_data_reg <= '0;
            rt_data_reg <= '0;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    rs_data_reg <= '0;
                    rt_data_reg <= '0;
                    if (clr_cnt_reg == ADDR_W'(DEPTH - 1)) begin
                        state_reg   <= ST_RUN;
                        ready_reg   <= 1'b1;
                        clr_cnt_reg <= '0;
                    end else begin
                        clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clear_i) begin
                        // Accepting edge: outputs keep their previous value.
                        state_reg   <= ST_CLEAR;
                        ready_reg   <= 1'b0;
                        clr_cnt_reg <= '0;
                    end else begin
                        rs_data_reg <= rs_data_next;
                        rt_data_reg <= rt_data_next;
                    end
                end
                default: begin
                    state_reg   <= ST_CLEAR;
                    clr_cnt_reg <= '0;
                    ready_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o  = ready_reg;
    assign RSdata_o = rs_data_reg;
    assign RTdata_o = rt_data_reg;

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: clear sequencing, bypass, collisions, zero reg, resets.
module tb_reg_file_mp;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        clear_i = 1'b0;
    logic        ready_o;
    logic [4:0]  RSaddr_i = '0;
    logic [4:0]  RTaddr_i = '0;
    logic [31:0] RSdata_o;
    logic [31:0] RTdata_o;
    logic        WE0_i = 1'b0;
    logic [4:0]  WA0_i = '0;
    logic [31:0] WD0_i = '0;
    logic        WE1_i = 1'b0;
    logic [4:0]  WA1_i = '0;
    logic [31:0] WD1_i = '0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model [32];
    logic [31:0] last_rs;
    logic [31:0] last_rt;

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .ready_o(ready_o),
        .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i),
        .RSdata_o(RSdata_o), .RTdata_o(RTdata_o),
        .WE0_i(WE0_i), .WA0_i(WA0_i), .WD0_i(WD0_i),
        .WE1_i(WE1_i), .WA1_i(WA1_i), .WD1_i(WD1_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic model_zero();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a,
                                             input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                                             input logic we1, input logic [4:0] wa1, input logic [31:0] wd1);
        if (a == 5'd0) return 32'h0;
        if (we1 && wa1 == a) return wd1;
        if (we0 && wa0 == a) return wd0;
        return model[a];
    endfunction

    // One RUN-mode transaction: drive, push expectation, clock, pop and compare.
    task automatic op(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                      input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                      input logic we1, input logic [4:0] wa1, input logic [31:0] wd1);
        exp_t e;
        RSaddr_i = rs; RTaddr_i = rt;
        WE0_i = we0; WA0_i = wa0; WD0_i = wd0;
        WE1_i = we1; WA1_i = wa1; WD1_i = wd1;
        e.rs = exp_read(rs, we0, wa0, wd0, we1, wa1, wd1);
        e.rt = exp_read(rt, we0, wa0, wd0, we1, wa1, wd1);
        sb_q.push_back(e);
        if (we0 && wa0 != 5'd0) model[wa0] = wd0;
        if (we1 && wa1 != 5'd0) model[wa1] = wd1;
        tick();
        WE0_i = 1'b0; WE1_i = 1'b0;
        e = sb_q.pop_front();
        chk({tag, "_rs"}, RSdata_o, e.rs);
        chk({tag, "_rt"}, RTdata_o, e.rt);
        last_rs = e.rs;
        last_rt = e.rt;
    endtask

    task automatic wait_ready(input string tag);
        for (int e = 1; e <= 32; e++) begin
            tick();
            chk(tag, {31'b0, ready_o}, {31'b0, e == 32});
        end
        model_zero();
    endtask

    initial begin
        model_zero();
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_ready", {31'b0, ready_o}, 32'h0);
        chk("rst_rs", RSdata_o, 32'h0);
        chk("rst_rt", RTdata_o, 32'h0);
        rst_i = 1'b0;
        wait_ready("init_ready");

        for (int i = 0; i < 32; i++)
            op("init_read", 5'(i), 5'(31 - i), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        op("byp_wr",   5'd5, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        op("byp_hold1", 5'd5, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        op("byp_hold2", 5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        op("coll_wr",  5'd0, 5'd7, 1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 32'h22222222);
        op("coll_rd",  5'd7, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        op("zero_wr",  5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF);
        op("zero_rd",  5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        op("p0only",   5'd9, 5'd0, 1'b1, 5'd9, 32'h0BADF00D, 1'b1, 5'd10, 32'h5A5A5A5A);
        op("p0only_rd", 5'd9, 5'd10, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        for (int i = 0; i < 24; i++)
            op("rand", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               1'($urandom), 5'($urandom_range(0, 31)), $urandom,
               1'($urandom), 5'($urandom_range(0, 31)), $urandom);

        // clear_i request during RUN
        op("clr_pre", 5'd3, 5'd3, 1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 32'h0);
        clear_i = 1'b1;
        RSaddr_i = 5'd9; RTaddr_i = 5'd3;
        WE0_i = 1'b1; WA0_i = 5'd9; WD0_i = 32'hAAAA5555;
        tick();
        clear_i = 1'b0;
        chk("clr_acc_ready", {31'b0, ready_o}, 32'h0);
        chk("clr_acc_rs_hold", RSdata_o, last_rs);
        chk("clr_acc_rt_hold", RTdata_o, last_rt);
        for (int k = 1; k <= 32; k++) begin
            WE0_i = 1'b1; WA0_i = 5'd3; WD0_i = 32'(k) | 32'hF000_0000;
            WE1_i = 1'b1; WA1_i = 5'd9; WD1_i = 32'hCCCC_0000 | 32'(k);
            clear_i = (k == 5);
            tick();
            chk("clr_ready", {31'b0, ready_o}, {31'b0, k == 32});
            chk("clr_rs0", RSdata_o, 32'h0);
        end
        clear_i = 1'b0; WE0_i = 1'b0; WE1_i = 1'b0;
        model_zero();
        op("clr_after", 5'd3, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // reset during RUN with live outputs
        op("run_pre", 5'd12, 5'd12, 1'b1, 5'd12, 32'hCAFEF00D, 1'b0, 5'd0, 32'h0);
        #2 rst_i = 1'b1;
        #1;
        chk("run_rst_rs", RSdata_o, 32'h0);
        chk("run_rst_rt", RTdata_o, 32'h0);
        chk("run_rst_ready", {31'b0, ready_o}, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        wait_ready("run_rst_ready_up");
        op("run_rst_rd", 5'd12, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // reset while the clear counter sits at 10
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        repeat (10) tick();
        #2 rst_i = 1'b1;
        #1;
        chk("clr_rst_rs", RSdata_o, 32'h0);
        chk("clr_rst_ready", {31'b0, ready_o}, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        wait_ready("clr_rst_ready_up");
        op("clr_rst_rd", 5'd12, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
